logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 req0 / req1  input  1  requester 0 / 1 requests an operation.
REQ-005 op0 / op1  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-006 a0, b0 / a1, b1  input  WIDTH  operands of requester 0 / 1.
REQ-007 gnt0 / gnt1  output  1  one-cycle accept pulse to requester 0 / 1.
REQ-008 res_valid  output  1  res_data and res_id hold a valid result.
REQ-009 res_data  output  WIDTH  operation result.
REQ-010 res_id  output  1  index of the requester that owns the result.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL implement a single shared bitwise logic unit behind a three-state FSM: IDLE, EXEC, HOLD.
REQ-014 IDLE: when at least one req is high, the block SHALL assert exactly one gnt combinationally in that cycle, capture the granted op, a and b into internal registers, and move to EXEC on the next edge.
REQ-015 IDLE with no req high: no gnt, state unchanged.
REQ-016 Arbitration: single requester -> grant it; both requesting -> grant the requester indicated by the priority pointer.
REQ-017 The priority pointer SHALL update on each grant to point at the non-granted requester (round-robin).
REQ-018 gnt0 and gnt1 SHALL never be high in the same cycle, and SHALL be low outside IDLE.
REQ-019 EXEC: the block SHALL compute the captured op bitwise across all WIDTH bits, register it into res_data, set res_id, set res_valid, and move to HOLD.
REQ-020 Latency: res_valid SHALL rise exactly 2 clock edges after the gnt cycle.
REQ-021 HOLD: res_valid, res_data and res_id SHALL stay stable until res_ready is sampled high.
REQ-022 HOLD with res_ready high: res_valid SHALL clear on that edge and the state SHALL return to IDLE; a grant becomes possible in the following cycle at the earliest.
REQ-023 Requesters SHALL hold req, op and operands stable until gnt; a req dropped before gnt is not serviced and is not an error.
REQ-024 req inputs SHALL be ignored in EXEC and HOLD; no request is queued internally.
REQ-025 Minimum spacing between consecutive grants: 3 cycles with res_ready held high.

Reset
REQ-026 While reset is high: state IDLE, priority pointer 0, res_valid 0, res_data 0, res_id 0, gnt0/gnt1 0, busy 0.
REQ-027 Reset asserted in EXEC or HOLD SHALL discard the in-flight operation; no result is delivered for it after reset is released.
REQ-028 The first cycle after reset is released SHALL accept a grant if a req is high.

Verification
REQ-029 OR: req0=1, op0=01, a0=0xF0F00000, b0=0x00000F0F -> gnt0 pulse, 2 edges later res_valid=1, res_data=0xF0F00F0F, res_id=0.
REQ-030 Contention: req0 and req1 both held high from reset release -> gnt0 first, gnt1 on the next grant; then req0 alone -> gnt0; pointer alternates over 4 back-to-back ops.
REQ-031 Backpressure: res_ready=0 for 5 cycles in HOLD with req1 high -> res_data stable, busy=1, no gnt; res_ready=1 -> res_valid clears, gnt1 in the next cycle.
REQ-032 Ops: a=0xAAAA5555, b=0xFFFF0000 -> AND 0xAAAA0000, XOR 0x55555555, NOR 0x0000AAAA.
REQ-033 Reset in HOLD: res_valid=1, then reset held 1 cycle -> res_valid=0, busy=0, pointer=0, and no stale result appears afterwards.
REQ-034 Every test: assert gnt0 and gnt1 are never both high, and res_data never changes while res_valid=1 and res_ready=0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter feeding one shared bitwise logic unit
// (AND/OR/XOR/NOR); a result is held until the consumer takes it.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [1:0]       i_op0,
    input  logic [1:0]       i_op1,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_res_valid,
    output logic [WIDTH-1:0] o_res_data,
    output logic             o_res_id,
    input  logic             i_res_ready,
    output logic             o_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t           r_state, w_next;
    logic             r_ptr, r_cap_id, r_res_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
    logic             w_idle, w_gnt0, w_gnt1;
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? ((i_req0 | i_req1) ? EXEC : IDLE) :
                 (r_state == EXEC) ? HOLD :
                 (i_res_ready ? IDLE : HOLD);
    end
    // Outputs are forced quiet while reset is asserted, whatever the current state.
    always_comb begin
        w_idle      = (r_state == IDLE) && !i_reset;
        w_gnt0      = w_idle && i_req0 && (!i_req1 || !r_ptr);
        w_gnt1      = w_idle && i_req1 && (!i_req0 || r_ptr);
        o_gnt0      = w_gnt0;
        o_gnt1      = w_gnt1;
        o_busy      = (r_state != IDLE) && !i_reset;
        o_res_valid = (r_state == HOLD) && !i_reset;
        o_res_data  = r_res;
        o_res_id    = r_res_id;
    end
    always_comb begin
        w_res = (r_op == 2'b00) ? (r_a & r_b) :
                (r_op == 2'b01) ? (r_a | r_b) :
                (r_op == 2'b10) ? (r_a ^ r_b) : ~(r_a | r_b);
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr    <= 1'b0;
            r_cap_id <= 1'b0;
            r_res_id <= 1'b0;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_op     <= w_gnt1 ? i_op1 : i_op0;
                r_a      <= w_gnt1 ? i_a1 : i_a0;
                r_b      <= w_gnt1 ? i_b1 : i_b0;
                r_cap_id <= w_gnt1;
                r_ptr    <= w_gnt0;
            end
            if (r_state == EXEC) begin
                r_res    <= w_res;
                r_res_id <= r_cap_id;
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed and random stimulus checked against a
// transaction-level scoreboard (grant rules, latency queue, hold-until-ready).
module tb_logic_unit_arbiter;
    localparam int W = 32;
    typedef struct {logic [W-1:0] d; logic id; int due;} res_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rdy = 1'b1;
    logic         req [2];
    logic [1:0]   op  [2];
    logic [W-1:0] a   [2];
    logic [W-1:0] b   [2];
    logic         gnt0, gnt1, res_valid, res_id, busy;
    logic [W-1:0] res_data;
    res_t         q[$];
    logic         ptr = 1'b0;
    logic [1:0]   last_g = 2'b00;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_req0(req[0]), .i_req1(req[1]),
        .i_op0(op[0]), .i_op1(op[1]),
        .i_a0(a[0]), .i_b0(b[0]), .i_a1(a[1]), .i_b1(b[1]),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_res_valid(res_valid), .o_res_data(res_data), .o_res_id(res_id),
        .i_res_ready(rdy), .o_busy(busy)
    );

    function automatic logic [W-1:0] calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT outputs with the scoreboard, then advance it at the edge.
    task automatic step();
        logic g0, g1, vis, free;
        #2;
        free = (q.size() == 0);
        g0   = !rst && free && req[0] && (!req[1] || !ptr);
        g1   = !rst && free && req[1] && (!req[0] || ptr);
        vis  = 1'b0;
        if (!rst && !free) vis = (cyc >= q[0].due);
        chk("gnt0", {31'b0, gnt0}, {31'b0, g0});
        chk("gnt1", {31'b0, gnt1}, {31'b0, g1});
        chk("busy", {31'b0, busy}, {31'b0, !rst && !free});
        chk("res_valid", {31'b0, res_valid}, {31'b0, vis});
        if (vis) begin
            chk("res_data", res_data, q[0].d);
            chk("res_id", {31'b0, res_id}, {31'b0, q[0].id});
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            ptr = 1'b0;
        end else begin
            if (vis && rdy) void'(q.pop_front());
            if (g0 || g1) begin
                q.push_back('{calc(op[g1], a[g1], b[g1]), g1, cyc + 1});
                ptr = g0;
            end
        end
        last_g = {g1, g0};
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        req[0] = 0; req[1] = 0; op[0] = 0; op[1] = 0;
        a[0] = 0; b[0] = 0; a[1] = 0; b[1] = 0;
        @(posedge clk); #1;
        steps(2);
        rst = 0;
        chk("rst_res_data", res_data, '0);
        chk("rst_res_id", {31'b0, res_id}, '0);
        // OR example
        req[0] = 1; op[0] = 2'b01; a[0] = 32'hF0F00000; b[0] = 32'h00000F0F;
        step();
        chk("or_gnt", {30'b0, last_g}, 32'd1);
        req[0] = 0;
        steps(2);
        chk("or_data", res_data, 32'hF0F00F0F);
        steps(2);
        // AND / XOR / NOR from requester 1
        a[1] = 32'hAAAA5555; b[1] = 32'hFFFF0000;
        for (int k = 0; k < 3; k++) begin
            logic [1:0]   ops [3];
            logic [W-1:0] exp [3];
            ops = '{2'b00, 2'b10, 2'b11};
            exp = '{32'hAAAA0000, 32'h55555555, 32'h0000AAAA};
            req[1] = 1; op[1] = ops[k];
            step();
            req[1] = 0;
            steps(2);
            chk("op_data", res_data, exp[k]);
            chk("op_id", {31'b0, res_id}, 32'd1);
            step();
        end
        // Contention straight out of reset
        rst = 1; step(); rst = 0;
        req[0] = 1; req[1] = 1; op[0] = 2'b10; op[1] = 2'b01;
        a[0] = 32'h12345678; b[0] = 32'h0F0F0F0F; a[1] = 32'h00FF00FF; b[1] = 32'h11110000;
        step();
        chk("first_gnt", {30'b0, last_g}, 32'd1);
        steps(2);
        step();
        chk("second_gnt", {30'b0, last_g}, 32'd2);
        steps(8);
        req[1] = 0;
        steps(6);
        req[0] = 0;
        steps(3);
        // Backpressure with requester 1 waiting
        req[0] = 1; op[0] = 2'b11; a[0] = 32'hDEADBEEF; b[0] = 32'h01234567;
        step();
        req[0] = 0; req[1] = 1; rdy = 0;
        steps(7);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        rdy = 1;
        step();
        step();
        chk("bp_gnt1", {30'b0, last_g}, 32'd2);
        req[1] = 0;
        steps(3);
        // Reset while holding a result
        req[0] = 1; op[0] = 2'b00; a[0] = 32'hFFFFFFFF; b[0] = 32'h5A5A5A5A;
        step();
        req[0] = 0; rdy = 0;
        steps(3);
        chk("hold_valid", {31'b0, res_valid}, 32'd1);
        rst = 1; step(); rst = 0;
        chk("post_rst_valid", {31'b0, res_valid}, '0);
        chk("post_rst_busy", {31'b0, busy}, '0);
        rdy = 1;
        steps(4);
        // Random traffic
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || last_g[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    op[i]  = 2'($urandom);
                    a[i]   = $urandom;
                    b[i]   = $urandom;
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0; rdy = 1; req[0] = 0; req[1] = 0;
        steps(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
